// File: rtl/dma_channel_sequencer_if.sv
// Memory-port and DMA-buffer signals between the channel sequencer and its surroundings.
interface dma_channel_sequencer_if;
    logic        bus_req;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [2:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_error;
    logic [31:0] bus_rdata;
    logic        buf_wr_en;
    logic [31:0] buf_wdata;
    logic        buf_rd_en;
    logic [2:0]  buf_size;
    logic        buf_response;
    logic [31:0] buf_rdata;

    modport master (
        output bus_req, bus_write, bus_addr, bus_size, bus_wdata,
        output buf_wr_en, buf_wdata, buf_rd_en, buf_size, buf_response,
        input  bus_ready, bus_error, bus_rdata, buf_rdata
    );

    modport slave (
        input  bus_req, bus_write, bus_addr, bus_size, bus_wdata,
        input  buf_wr_en, buf_wdata, buf_rd_en, buf_size, buf_response,
        output bus_ready, bus_error, bus_rdata, buf_rdata
    );
endinterface

// File: rtl/dma_channel_sequencer.sv
// Per-channel DMA sequencer: copies beats src->buffer->dst in chunks of up to BURST_LEN.
// Latency: start -> bus_req next cycle, one beat/cycle; backpressure: request held until bus_ready.
module dma_channel_sequencer #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            src_addr,
    input  logic [31:0]            dst_addr,
    input  logic                   src_incr,
    input  logic                   dst_incr,
    input  logic [2:0]             transfer_size,
    input  logic [CNT_W-1:0]       transfer_count,
    dma_channel_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

    state_t           state;
    logic [31:0]      src_ptr, dst_ptr, addr_q;
    logic [CNT_W-1:0] remaining, rem_after;
    logic [BW-1:0]    chunk, beat_cnt;
    logic [2:0]       size_q, size_clamp;
    logic             src_incr_q, dst_incr_q, req_q, write_q, resp_q;
    logic [31:0]      step, src_next, dst_next;
    logic             misaligned, beat, last_beat;

    function automatic logic [BW-1:0] chunk_of(input logic [CNT_W-1:0] n);
        if (n >= CNT_W'(BURST_LEN))
            return BW'(BURST_LEN);
        return n[BW-1:0];
    endfunction

    assign size_clamp = (transfer_size > 3'd2) ? 3'd2 : transfer_size;

    always_comb begin
        misaligned = 1'b0;
        case (size_clamp)
            3'd1:    misaligned = src_addr[0] | dst_addr[0];
            3'd2:    misaligned = (|src_addr[1:0]) | (|dst_addr[1:0]);
            default: misaligned = 1'b0;
        endcase
    end

    assign step      = 32'd1 << size_q;
    assign src_next  = src_incr_q ? src_ptr + step : src_ptr;
    assign dst_next  = dst_incr_q ? dst_ptr + step : dst_ptr;
    assign beat      = req_q & bus.bus_ready;
    assign last_beat = (beat_cnt == chunk - BW'(1));
    assign rem_after = remaining - CNT_W'(chunk);

    assign bus.bus_req      = req_q;
    assign bus.bus_write    = write_q;
    assign bus.bus_addr     = addr_q;
    assign bus.bus_size     = size_q;
    assign bus.buf_size     = size_q;
    assign bus.buf_response = resp_q;
    assign bus.bus_wdata    = write_q ? bus.buf_rdata : 32'd0;
    // An errored beat is neither pushed into nor popped from the buffer.
    assign bus.buf_wr_en    = (state == S_READ) & beat & ~bus.bus_error;
    assign bus.buf_wdata    = (state == S_READ) ? bus.bus_rdata : 32'd0;
    assign bus.buf_rd_en    = (state == S_WRITE) & beat & ~bus.bus_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            addr_q     <= '0;
            remaining  <= '0;
            chunk      <= '0;
            beat_cnt   <= '0;
            size_q     <= '0;
            src_incr_q <= 1'b0;
            dst_incr_q <= 1'b0;
            req_q      <= 1'b0;
            write_q    <= 1'b0;
            resp_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done   <= 1'b0;
            resp_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    size_q     <= size_clamp;
                    src_ptr    <= src_addr;
                    dst_ptr    <= dst_addr;
                    src_incr_q <= src_incr;
                    dst_incr_q <= dst_incr;
                    remaining  <= transfer_count;
                    chunk      <= chunk_of(transfer_count);
                    beat_cnt   <= '0;
                    error      <= 1'b0;
                    busy       <= 1'b1;
                    if (transfer_count == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (misaligned) begin
                        state  <= S_ERR;
                        error  <= 1'b1;
                        resp_q <= 1'b1;
                    end else begin
                        state   <= S_READ;
                        req_q   <= 1'b1;
                        write_q <= 1'b0;
                        addr_q  <= src_addr;
                    end
                end
                S_READ, S_WRITE: if (beat) begin
                    if (bus.bus_error) begin
                        state   <= S_ERR;
                        error   <= 1'b1;
                        resp_q  <= 1'b1;
                        req_q   <= 1'b0;
                        write_q <= 1'b0;
                    end else begin
                        if (state == S_READ) src_ptr <= src_next;
                        else                 dst_ptr <= dst_next;
                        // Abort is only honoured here, between beats, so no beat is ever cut short.
                        if (abort) begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            req_q   <= 1'b0;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else if (!last_beat) begin
                            beat_cnt <= beat_cnt + BW'(1);
                            addr_q   <= (state == S_READ) ? src_next : dst_next;
                        end else if (state == S_READ) begin
                            state    <= S_WRITE;
                            beat_cnt <= '0;
                            write_q  <= 1'b1;
                            addr_q   <= dst_ptr;
                        end else begin
                            remaining <= rem_after;
                            beat_cnt  <= '0;
                            write_q   <= 1'b0;
                            if (rem_after != '0) begin
                                state  <= S_READ;
                                chunk  <= chunk_of(rem_after);
                                addr_q <= src_ptr;
                            end else begin
                                state <= S_DONE;
                                req_q <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Scoreboarded bench for dma_channel_sequencer with a memory slave and a fall-through buffer model.
module tb_dma_channel_sequencer;
    localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3, K_ABT = 4;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          at;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic        src_incr = 1'b0;
    logic        dst_incr = 1'b0;
    logic [2:0]  transfer_size = '0;
    logic [15:0] transfer_count = '0;
    logic        busy, done, error;

    dma_channel_sequencer_if bus();

    dma_channel_sequencer #(.BURST_LEN(4), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .src_incr       (src_incr),
        .dst_incr       (dst_incr),
        .transfer_size  (transfer_size),
        .transfer_count (transfer_count),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    ev_t exp_q[$];
    logic [31:0] bq[$];
    int n_wr = 0, n_rd = 0, n_resp = 0;
    int ws = 0, err_beat = 0, beat_no = 0;
    logic        pend_push = 1'b0, pend_pop = 1'b0, pend_flush = 1'b0;
    logic [31:0] pend_dat = '0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] addr, input logic [31:0] data, input int at);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        int rel;
        rel = cyc - t0;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h cycle=%0d expected none",
                     kind, addr, data, rel);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr !== addr || e.data !== data || (e.at >= 0 && e.at != rel)) begin
                bad++;
                $display("FAIL event: got kind=%0d addr=%h data=%h cycle=%0d expected kind=%0d addr=%h data=%h cycle=%0d",
                         kind, addr, data, rel, e.kind, e.addr, e.data, e.at);
            end
        end
    endtask

    // Memory slave with programmable wait states and error injection, plus the buffer model.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.bus_ready = 1'b0;
        bus.bus_error = 1'b0;
        bus.bus_rdata = '0;
        bus.buf_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset || pend_flush) bq.delete();
            else begin
                if (pend_pop && bq.size() > 0) void'(bq.pop_front());
                if (pend_push) bq.push_back(pend_dat);
            end
            bus.buf_rdata = (bq.size() > 0) ? bq[0] : 32'd0;
            bus.bus_rdata = rd_fn(bus.bus_addr);
            if (bus.bus_req) begin
                if (wcnt >= ws) begin
                    wcnt = 0;
                    beat_no++;
                    bus.bus_ready = 1'b1;
                    bus.bus_error = (beat_no == err_beat);
                end else begin
                    wcnt++;
                    bus.bus_ready = 1'b0;
                    bus.bus_error = 1'b0;
                end
            end else begin
                wcnt = 0;
                bus.bus_ready = 1'b0;
                bus.bus_error = 1'b0;
            end
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queue.
    initial begin
        logic        prev_wait, prev_write;
        logic [31:0] prev_addr;
        prev_wait = 1'b0; prev_write = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_push = 1'b0; pend_pop = 1'b0; pend_flush = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if (prev_wait)
                    check("hold_req", {31'd0, bus.bus_req, bus.bus_write, bus.bus_addr},
                          {31'd0, 1'b1, prev_write, prev_addr});
                if (bus.bus_req && bus.bus_ready && !bus.bus_error)
                    got_ev(bus.bus_write ? K_WR : K_RD, bus.bus_addr,
                           bus.bus_write ? bus.bus_wdata : bus.buf_wdata);
                if (done) got_ev(K_DONE, 32'd0, 32'd0);
                if (bus.buf_response) got_ev(error ? K_ERR : K_ABT, 32'd0, 32'd0);
                prev_wait  = bus.bus_req && !bus.bus_ready;
                prev_write = bus.bus_write;
                prev_addr  = bus.bus_addr;
                if (bus.buf_wr_en) n_wr++;
                if (bus.buf_rd_en) n_rd++;
                if (bus.buf_response) n_resp++;
                pend_push  = bus.buf_wr_en;
                pend_dat   = bus.buf_wdata;
                pend_pop   = bus.buf_rd_en;
                pend_flush = bus.buf_response;
            end
        end
    end

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic si, input logic di,
                          input logic [2:0] sz, input logic [15:0] cnt);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; src_incr = si; dst_incr = di;
        transfer_size = sz; transfer_count = cnt;
        n_wr = 0; n_rd = 0; n_resp = 0; beat_no = 0;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_timeout"}, 64'(k < 300), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bus_req", 64'(bus.bus_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_buf_response", 64'(bus.buf_response), 64'd0);
        check("rst_bus_addr", 64'(bus.bus_addr), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);

        // Word copy, single chunk, exact cycle positions.
        ws = 0; err_beat = 0;
        for (int i = 0; i < 4; i++) expect_ev(K_RD, 32'h100 + 32'(4*i), rd_fn(32'h100 + 32'(4*i)), 1 + i);
        for (int i = 0; i < 4; i++) expect_ev(K_WR, 32'h200 + 32'(4*i), rd_fn(32'h100 + 32'(4*i)), 5 + i);
        expect_ev(K_DONE, 32'd0, 32'd0, 9);
        launch(32'h100, 32'h200, 1'b1, 1'b1, 3'd2, 16'd4);
        repeat (8) @(posedge clk);
        #1;
        check("t1_busy_at_done", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("t1_busy_after_done", 64'(busy), 64'd0);
        wait_idle("t1");

        // Byte copy, 6 beats: chunks of 4 then 2, fixed destination.
        for (int i = 0; i < 4; i++) expect_ev(K_RD, 32'h41 + 32'(i), rd_fn(32'h41 + 32'(i)), 1 + i);
        for (int i = 0; i < 4; i++) expect_ev(K_WR, 32'h80, rd_fn(32'h41 + 32'(i)), 5 + i);
        for (int i = 0; i < 2; i++) expect_ev(K_RD, 32'h45 + 32'(i), rd_fn(32'h45 + 32'(i)), 9 + i);
        for (int i = 0; i < 2; i++) expect_ev(K_WR, 32'h80, rd_fn(32'h45 + 32'(i)), 11 + i);
        expect_ev(K_DONE, 32'd0, 32'd0, 13);
        launch(32'h41, 32'h80, 1'b1, 1'b0, 3'd0, 16'd6);
        wait_idle("t2");
        check("t2_wr_pulses", 64'(n_wr), 64'd6);
        check("t2_rd_pulses", 64'(n_rd), 64'd6);

        // Halfword copy with two wait states per beat.
        ws = 2;
        expect_ev(K_RD, 32'h300, rd_fn(32'h300), 3);
        expect_ev(K_RD, 32'h302, rd_fn(32'h302), 6);
        expect_ev(K_WR, 32'h400, rd_fn(32'h300), 9);
        expect_ev(K_WR, 32'h402, rd_fn(32'h302), 12);
        expect_ev(K_DONE, 32'd0, 32'd0, 13);
        launch(32'h300, 32'h400, 1'b1, 1'b1, 3'd1, 16'd2);
        check("t3_bus_size", 64'(bus.bus_size), 64'd1);
        wait_idle("t3");
        check("t3_wr_pulses", 64'(n_wr), 64'd2);
        check("t3_rd_pulses", 64'(n_rd), 64'd2);
        ws = 0;

        // Bus error on the second read beat.
        err_beat = 2;
        expect_ev(K_RD, 32'h500, rd_fn(32'h500), 1);
        expect_ev(K_ERR, 32'd0, 32'd0, 3);
        launch(32'h500, 32'h600, 1'b1, 1'b1, 3'd2, 16'd4);
        wait_idle("t4");
        check("t4_error", 64'(error), 64'd1);
        check("t4_resp_pulses", 64'(n_resp), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        err_beat = 0;

        // Zero-count start: done only, and it clears the sticky error.
        expect_ev(K_DONE, 32'd0, 32'd0, 1);
        launch(32'h0, 32'h0, 1'b1, 1'b1, 3'd2, 16'd0);
        check("t5_error_cleared", 64'(error), 64'd0);
        wait_idle("t5");

        // Misaligned word source.
        expect_ev(K_ERR, 32'd0, 32'd0, 1);
        launch(32'h102, 32'h200, 1'b1, 1'b1, 3'd2, 16'd4);
        wait_idle("t6");
        check("t6_error", 64'(error), 64'd1);
        check("t6_no_beats", 64'(n_wr), 64'd0);

        // Abort raised during beat 3 of 8.
        for (int i = 0; i < 3; i++) expect_ev(K_RD, 32'h700 + 32'(4*i), rd_fn(32'h700 + 32'(4*i)), 1 + i);
        expect_ev(K_ABT, 32'd0, 32'd0, 4);
        launch(32'h700, 32'h800, 1'b1, 1'b1, 3'd2, 16'd8);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle("t7");
        check("t7_resp_pulses", 64'(n_resp), 64'd1);
        check("t7_error", 64'(error), 64'd0);

        // Out-of-range size is treated as word.
        expect_ev(K_RD, 32'h900, rd_fn(32'h900), 1);
        expect_ev(K_WR, 32'hA00, rd_fn(32'h900), 2);
        expect_ev(K_DONE, 32'd0, 32'd0, 3);
        launch(32'h900, 32'hA00, 1'b1, 1'b1, 3'd7, 16'd1);
        check("t8_bus_size", 64'(bus.bus_size), 64'd2);
        check("t8_buf_size", 64'(bus.buf_size), 64'd2);
        wait_idle("t8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
